// File: rtl/token_run_meter.sv
// Purpose: measures maximal runs of '1' tokens and queues {sat, len[, gap]} records in a show-ahead FIFO.
// Latency: a record is visible one cycle after its terminating '0' (empty FIFO); a pop advances the head at the same edge.
// Backpressure: run_ready stalls the FIFO; a record arriving while full with no same-cycle pop is dropped and sets sticky overflow.
// Option: define TOKEN_RUN_METER_GAP_EN to store the preceding zero count with each record (run_gap port).

module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    // Extra pointer MSB separates full from empty when the slot indices match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld = !empty;
    assign pop    = rd_vld && rd_rdy;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_rdy = !full || pop;
    assign push   = wr_vld && wr_rdy;
    // Head shows zero when nothing is queued, so reset presents all-zero outputs.
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer advance on push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

module token_run_meter #(
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    output logic             run_valid,
    input  logic             run_ready,
    output logic [LEN_W-1:0] run_len,
    output logic             run_sat,
`ifdef TOKEN_RUN_METER_GAP_EN
    output logic [LEN_W-1:0] run_gap,
`endif
    output logic             overflow
);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
`ifdef TOKEN_RUN_METER_GAP_EN
        logic [LEN_W-1:0] gap;
`endif
        logic             sat;
        logic [LEN_W-1:0] len;
    } rec_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic             sat;
    logic             sat_nxt;
    logic             rec_push;
    logic             fifo_wr_rdy;
    rec_t             rec;
    rec_t             head;
`ifdef TOKEN_RUN_METER_GAP_EN
    logic [LEN_W-1:0] gap_cnt;
    logic [LEN_W-1:0] gap_cnt_nxt;
    logic [LEN_W-1:0] gap_lat;
    logic [LEN_W-1:0] gap_lat_nxt;
`endif

    // Run FSM next state, saturating length count and record push.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        rec_push  = 1'b0;
`ifdef TOKEN_RUN_METER_GAP_EN
        gap_lat_nxt = gap_lat;
        gap_cnt_nxt = gap_cnt;
        if (!a && (gap_cnt != LEN_MAX)) gap_cnt_nxt = gap_cnt + LEN_ONE;
`endif
        case (state)
            IDLE: begin
                if (a) begin
                    state_nxt = RUN;
                    cnt_nxt   = LEN_ONE;
                    sat_nxt   = 1'b0;
`ifdef TOKEN_RUN_METER_GAP_EN
                    gap_lat_nxt = gap_cnt;
                    gap_cnt_nxt = '0;
`endif
                end
            end
            RUN: begin
                if (a) begin
                    if (cnt == LEN_MAX) sat_nxt = 1'b1;
                    else                cnt_nxt = cnt + LEN_ONE;
                end else begin
                    rec_push  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sat   <= 1'b0;
`ifdef TOKEN_RUN_METER_GAP_EN
            gap_cnt <= '0;
            gap_lat <= '0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat_nxt;
`ifdef TOKEN_RUN_METER_GAP_EN
            gap_cnt <= gap_cnt_nxt;
            gap_lat <= gap_lat_nxt;
`endif
        end
    end

    // Record assembled from the live counters at the terminating zero.
    always_comb begin
        rec     = '0;
        rec.len = cnt;
        rec.sat = sat;
`ifdef TOKEN_RUN_METER_GAP_EN
        rec.gap = gap_lat;
`endif
    end

    fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (rec_push),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat (rec),
        .rd_vld (run_valid),
        .rd_rdy (run_ready),
        .rd_dat (head)
    );

    assign run_len = head.len;
    assign run_sat = head.sat;
`ifdef TOKEN_RUN_METER_GAP_EN
    assign run_gap = head.gap;
`endif

    // Sticky flag for a completed record that found no room.
    always_ff @(posedge clk) begin
        if (rst)                           overflow <= 1'b0;
        else if (rec_push && !fifo_wr_rdy) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_token_run_meter.sv
// Purpose: directed self-checking bench for token_run_meter with hand-computed records.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: run_ready is driven per scenario to exercise stall, overflow and same-cycle pop.
module tb_token_run_meter;
    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       run_valid;
    logic       run_ready;
    logic [7:0] run_len;
    logic       run_sat;
`ifdef TOKEN_RUN_METER_GAP_EN
    logic [7:0] run_gap;
`endif
    logic       overflow;

    int n_chk  = 0;
    int n_pass = 0;

    string s_run = "11011011110111111001111110";
    string s_vld = "00100100001000000100000001";
    int    exp_len [5] = '{2, 2, 4, 6, 6};
    int    k;

    token_run_meter #(.LEN_W(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .run_valid (run_valid),
        .run_ready (run_ready),
        .run_len   (run_len),
        .run_sat   (run_sat),
`ifdef TOKEN_RUN_METER_GAP_EN
        .run_gap   (run_gap),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic ones(input int n);
        a = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; a = 1'b0; run_ready = 1'b0;
        tick(); tick();
        check("rst_valid", run_valid, 0);
        check("rst_len",   run_len,   0);
        check("rst_sat",   run_sat,   0);
        check("rst_ovf",   overflow,  0);
        rst = 1'b0;

        // Run lengths with consumer always ready.
        run_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 26; i++) begin
            a = (s_run[i] == "1");
            tick();
            check($sformatf("rl_valid_%0d", i), run_valid, (s_vld[i] == "1"));
            if (s_vld[i] == "1") begin
                check($sformatf("rl_len_%0d", k), run_len, exp_len[k]);
                check($sformatf("rl_sat_%0d", k), run_sat, 0);
                k++;
            end
        end
        a = 1'b0; tick();
        check("rl_drained", run_valid, 0);

        // Overflow: five single-token runs into a stalled 4-deep FIFO.
        run_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 1'b1; tick();
            a = 1'b0; tick();
        end
        check("ovf_before", overflow, 0);
        a = 1'b1; tick();
        a = 1'b0; tick();
        check("ovf_set", overflow, 1);
        run_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_pop_vld_%0d", i), run_valid, 1);
            check($sformatf("ovf_pop_len_%0d", i), run_len, 1);
            tick();
        end
        check("ovf_empty", run_valid, 0);
        check("ovf_sticky", overflow, 1);
        ones(3);
        a = 1'b0; tick();
        check("ovf_next_len", run_len, 3);
        check("ovf_next_vld", run_valid, 1);
        tick();
        check("ovf_still", overflow, 1);

        // Saturation boundaries.
        rst = 1'b1; tick(); rst = 1'b0;
        check("sat_rst_ovf", overflow, 0);
        ones(255); a = 1'b0; tick();
        check("sat255_len", run_len, 255);
        check("sat255_sat", run_sat, 0);
        ones(256); a = 1'b0; tick();
        check("sat256_len", run_len, 255);
        check("sat256_sat", run_sat, 1);
        ones(300); a = 1'b0; tick();
        check("sat300_len", run_len, 255);
        check("sat300_sat", run_sat, 1);
        tick();
        check("sat_drained", run_valid, 0);

        // Full FIFO with a push and a pop on the same edge.
        run_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 1'b1; tick();
            a = 1'b0; tick();
        end
        ones(2);
        a = 1'b0; run_ready = 1'b1; tick();
        check("fp_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fp_vld_%0d", i), run_valid, 1);
            check($sformatf("fp_len_%0d", i), run_len, (i == 3) ? 2 : 1);
            tick();
        end
        check("fp_empty", run_valid, 0);

        // Reset mid-run discards the partial run and queued records.
        run_ready = 1'b0;
        ones(2); a = 1'b0; tick();
        check("mr_queued", run_valid, 1);
        ones(10);
        a = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        check("mr_valid", run_valid, 0);
        check("mr_len",   run_len,   0);
        check("mr_sat",   run_sat,   0);
        check("mr_ovf",   overflow,  0);
        ones(3); a = 1'b0; tick();
        check("mr_rec_vld", run_valid, 1);
        check("mr_rec_len", run_len, 3);
        run_ready = 1'b1; tick();
        check("mr_one_only", run_valid, 0);

`ifdef TOKEN_RUN_METER_GAP_EN
        // Gap counts: 000 11 0 1 0 after reset.
        rst = 1'b1; run_ready = 1'b0; tick(); rst = 1'b0;
        a = 1'b0; tick(); tick(); tick();
        ones(2); a = 1'b0; tick();
        ones(1); a = 1'b0; tick();
        check("gap0_gap", run_gap, 3);
        check("gap0_len", run_len, 2);
        run_ready = 1'b1; tick();
        check("gap1_gap", run_gap, 1);
        check("gap1_len", run_len, 1);
        tick();
        check("gap_empty", run_valid, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/token_run_meter.md
# token_run_meter

Serial run-length meter for token streams. It sits directly downstream of the token-doubling stage and consumes its serial output. It measures every maximal run of consecutive '1' tokens and queues one length record per run into a small show-ahead FIFO. Records leave through a valid/ready interface toward the statistics/checker logic. A sticky overflow flag reports records lost to back-pressure.

## Interface
- `LEN_W`, default 8: width of run-length and gap counters. Maximum reportable value is 2^LEN_W-1.
- `FIFO_DEPTH`, default 4: number of record slots. Must be a power of two, ≥2.
- `clk`  in  1  single clock; every signal is sampled on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `a`  in  1  serial token stream, one token per cycle (the doubling stage's `b`).
- `run_valid`  out  1  the FIFO head record is available.
- `run_ready`  in  1  the consumer accepts the head record.
- `run_len`  out  LEN_W  length of the head record, saturated.
- `run_sat`  out  1  the head record's true length exceeded 2^LEN_W-1.
- `run_gap`  out  LEN_W  zeros preceding the head run. Present only with `TOKEN_RUN_METER_GAP_EN`.
- `overflow`  out  1  sticky; a completed record was dropped.

## Operation
- The state machine has two states:
  - IDLE: last sampled `a`=0.
  - RUN: counting ones.
- IDLE, `a`=1: go to RUN; count←1; sat←0.
- IDLE, `a`=0: stay in IDLE.
- RUN, `a`=1: stay in RUN.
  - If count < max: count←count+1.
  - If count = max: count holds at max and sat←1.
- RUN, `a`=0: the run completes.
  - Push {sat, count} (plus gap, if enabled) into the FIFO.
  - Go to IDLE.
- Saturation boundary: a run of exactly 2^LEN_W-1 ones reports len=max, sat=0. One more '1' reports len=max, sat=1.
- A run is reported only after its terminating '0'. A run still open stays uncounted indefinitely.
- FIFO behaviour:
  - Show-ahead: `run_len`, `run_sat` and `run_gap` always present the head entry.
  - A pop occurs when `run_valid` && `run_ready`.
  - Outputs hold stable while `run_valid` && !`run_ready`.
- Push while full:
  - With a same-cycle pop: the push is accepted and occupancy is unchanged.
  - Without a pop: the record is dropped, FIFO contents are untouched, and `overflow`←1.
- `overflow` clears only on `rst`. A dropped record does not affect the following runs.
- Push/pop pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an extra pointer bit or a counter (full ≠ empty).
- `run_ready` while empty has no effect.

## Timing
- Run samples: ones sampled at edges t0..t0+n-1 and a zero sampled at edge t0+n.
- If the FIFO is empty, `run_valid`=1 and `run_len`=n are visible right after edge t0+n. This is one cycle of latency from the terminating zero.
- Pop at edge p: the next entry (or `run_valid`=0) is visible right after edge p.
- No combinational path from `a` or `run_ready` to any output. All outputs are registered or come straight from FIFO storage and pointers.
- Back-to-back runs "1010…" produce one push every 2 cycles. With `run_ready`=1 held, the FIFO never fills.
- Reset values: state IDLE, count 0, sat 0, gap 0, FIFO empty, `run_valid` 0, `run_len` 0, `run_sat` 0, `run_gap` 0, `overflow` 0.
- Reset mid-run discards the partial run. Reset also discards all queued records, regardless of `run_ready`.

## Configuration
- `TOKEN_RUN_METER_GAP_EN` defined:
  - A gap counter counts '0' samples since reset or since the previous run completed. The terminating zero counts as gap.
  - The gap counter saturates at 2^LEN_W-1.
  - On IDLE→RUN its value is latched and stored with the record; the counter then clears.
  - `run_gap` port is present; the FIFO entry width is 2·LEN_W+1.
- Not defined:
  - No gap counter and no `run_gap` port.
  - FIFO entry width is LEN_W+1.
  - All other behaviour is identical.

## Test plan
- Run lengths: `run_ready`=1, `a` = 11011011110111111001111110 → records len 2,2,4,6,6, all sat=0. Each `run_valid` pulse appears one cycle after its terminating 0.
- Overflow: `run_ready`=0, `a` = "10" ×5 → 4 records stored, 5th dropped, `overflow`=1. Then `run_ready`=1 → pops 1,1,1,1, then `run_valid`=0. `overflow` stays 1 until `rst`.
- Saturation: LEN_W=8, 255 ones then 0 → len 255, sat 0. 300 ones then 0 → len 255, sat 1.
- Full with same-cycle pop: FIFO full, a run completes in the same cycle as a pop → record accepted, occupancy stays 4, `overflow`=0.
- Reset mid-run: 10 ones, `rst` for 1 cycle, 3 ones, 0 → exactly one record, len 3. All outputs are 0 the cycle after `rst`.
- GAP_EN: after reset, `a` = 000 11 0 1 0 → records (gap 3, len 2) and (gap 1, len 1).
